fft_frame_buffer: RTL

Ping-pong frame buffer that collects the streaming audio sample stream into N-sample frames and feeds them to the radix-4 FFT core. It sits between the sample source (ADC/I2S deserializer) and `fft_16`. It drives the FFT's parallel `time_samples` array and its one-cycle `start`, and uses the FFT's `done` to release the frame for reuse. While the FFT consumes one bank, the other bank keeps filling. Samples that arrive when both banks are occupied are dropped and counted.

---
 rtl/fft_frame_buffer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_buffer
// Purpose  : Ping-pong frame buffer between a streaming sample source and the
//            parallel-input FFT core. One bank fills while the other is held
//            stable on frame_samples for the FFT. Samples arriving while both
//            banks are occupied are dropped, flagged and counted.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_buffer #(
    parameter int WIDTH = 18,
    parameter int N     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic signed [WIDTH-1:0] frame_samples [0:N-1],
    output logic                    fft_start,
    input  logic                    fft_done,
    output logic                    overrun,
    output logic [7:0]              drop_count
);

    // Write pointer width and its wrap value
    localparam int                c_WP_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_WP_W-1:0] c_WP_LAST = c_WP_W'(N - 1);

    // FFT hand-off state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_BUSY  = 2'd2;

    localparam logic [7:0] c_DROP_MAX = 8'hFF;

    // Two banks of frame storage; bank r_wr_bank fills, the other is read
    logic signed [WIDTH-1:0] r_bank [0:1][0:N-1];

    logic              r_wr_bank;
    logic [c_WP_W-1:0] r_wp;
    logic              r_bank_full;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_overrun;
    logic [7:0]        r_drop_count;

    logic              w_swap;
    logic              w_accept;
    logic              w_drop;

    // A full write bank is handed to the FFT when the FFT is free or is
    // finishing on this very edge (back-to-back frames, no idle gap).
    assign w_swap   = r_bank_full &&
                      ((r_state == c_ST_IDLE) ||
                       ((r_state == c_ST_BUSY) && fft_done));

    // Normal write into the current bank: only while it still has room.
    assign w_accept = sample_valid && !r_bank_full;

    // Both banks occupied and no hand-off this edge: the sample is lost.
    assign w_drop   = sample_valid && r_bank_full && !w_swap;

    // Sample storage: normal writes go to the fill bank; on a swap edge a
    // valid sample lands at index 0 of the bank that becomes the fill bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
        end else if (w_swap) begin
            if (sample_valid) begin
                r_bank[~r_wr_bank][0] <= sample_in;
            end
        end else if (w_accept) begin
            r_bank[r_wr_bank][r_wp] <= sample_in;
        end
    end

    // Bank select, write pointer and full flag bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank   <= 1'b0;
            r_wp        <= '0;
            r_bank_full <= 1'b0;
        end else if (w_swap) begin
            r_wr_bank   <= ~r_wr_bank;
            r_bank_full <= 1'b0;
            r_wp        <= sample_valid ? c_WP_W'(1) : '0;
        end else if (w_accept) begin
            if (r_wp == c_WP_LAST) begin
                r_wp        <= '0;
                r_bank_full <= 1'b1;
            end else begin
                r_wp        <= r_wp + c_WP_W'(1);
            end
        end
    end

    // Overrun pulse and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun    <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_overrun <= w_drop;
            if (w_drop && (r_drop_count != c_DROP_MAX)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    // FFT hand-off state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and start decode; fft_done outside BUSY is ignored
    always_comb begin
        w_state_nxt = r_state;
        fft_start   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_swap) begin
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                fft_start   = 1'b1;
                w_state_nxt = c_ST_BUSY;
            end
            c_ST_BUSY: begin
                if (fft_done) begin
                    w_state_nxt = w_swap ? c_ST_START : c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Read bank drives the FFT input array; it is never written while read
    genvar g_i;
    generate
        for (g_i = 0; g_i < N; g_i++) begin : g_rd
            assign frame_samples[g_i] = r_bank[~r_wr_bank][g_i];
        end
    endgenerate

    assign overrun    = r_overrun;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire
